// File: rtl/dcpu_fetch.sv
// Instruction fetch unit for the dcpu core: demand reads over a req/ack memory bus
// plus a one-entry buffer that holds the prefetched sequential word (PC+1).
module dcpu_fetch #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned TIMEOUT    = 15
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_fetch,
    input  logic [ADDR_WIDTH-1:0] i_pc,
    input  logic                  i_flush,
    output logic [DATA_WIDTH-1:0] o_instruction,
    output logic                  o_instruction_valid,
    output logic                  o_bus_error,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic                  o_mem_rd,
    input  logic [DATA_WIDTH-1:0] i_mem_data,
    input  logic                  i_mem_ack
);

    localparam int unsigned CNT_WIDTH = 8;

    typedef enum logic [1:0] {IDLE, READ, PREFETCH, PF_WAIT} state_t;

    state_t                 state;
    logic                   buf_valid;
    logic [ADDR_WIDTH-1:0]  buf_addr;
    logic [DATA_WIDTH-1:0]  buf_data;
    logic                   pf_pend;
    logic [ADDR_WIDTH-1:0]  pf_addr;
    logic                   pf_discard;
    logic [ADDR_WIDTH-1:0]  pend_pc;
    logic [CNT_WIDTH-1:0]   tcount;

    logic timeout_c;
    logic done_c;
    logic hit_c;
    logic promote_c;

    // An ack in the last allowed cycle wins over the timeout.
    assign timeout_c = o_mem_rd && !i_mem_ack && (tcount == CNT_WIDTH'(TIMEOUT - 1));
    assign done_c    = o_mem_rd && (i_mem_ack || timeout_c);
    assign hit_c     = i_fetch && !i_flush && buf_valid && (buf_addr == i_pc);
    assign promote_c = i_fetch && !i_flush && !pf_discard && (i_pc == o_mem_addr);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state               <= IDLE;
            o_instruction       <= '0;
            o_instruction_valid <= 1'b0;
            o_bus_error         <= 1'b0;
            o_mem_addr          <= '0;
            o_mem_rd            <= 1'b0;
            buf_valid           <= 1'b0;
            buf_addr            <= '0;
            buf_data            <= '0;
            pf_pend             <= 1'b0;
            pf_addr             <= '0;
            pf_discard          <= 1'b0;
            pend_pc             <= '0;
            tcount              <= '0;
        end else begin
            o_instruction_valid <= 1'b0;
            o_bus_error         <= 1'b0;
            if (o_mem_rd && !done_c) begin
                tcount <= tcount + CNT_WIDTH'(1);
            end

            case (state)
                IDLE: begin
                    if (i_flush) begin
                        buf_valid <= 1'b0;
                        pf_pend   <= 1'b0;
                    end
                    if (i_fetch) begin
                        buf_valid <= 1'b0;
                        pf_pend   <= 1'b0;
                        if (hit_c) begin
                            o_instruction_valid <= 1'b1;
                            o_instruction       <= buf_data;
                            pf_pend             <= 1'b1;
                            pf_addr             <= i_pc + ADDR_WIDTH'(1);
                        end else begin
                            o_mem_rd   <= 1'b1;
                            o_mem_addr <= i_pc;
                            tcount     <= '0;
                            state      <= READ;
                        end
                    end else if (pf_pend && !i_flush) begin
                        o_mem_rd   <= 1'b1;
                        o_mem_addr <= pf_addr;
                        tcount     <= '0;
                        pf_pend    <= 1'b0;
                        pf_discard <= 1'b0;
                        state      <= PREFETCH;
                    end
                end

                // A prefetch whose address matches the fetch becomes the demand read in place.
                READ, PREFETCH: begin
                    if (state == READ || promote_c) begin
                        state <= READ;
                        if (i_mem_ack) begin
                            o_mem_rd            <= 1'b0;
                            o_instruction_valid <= 1'b1;
                            o_instruction       <= i_mem_data;
                            pf_pend             <= 1'b1;
                            pf_addr             <= o_mem_addr + ADDR_WIDTH'(1);
                            state               <= IDLE;
                        end else if (timeout_c) begin
                            o_mem_rd    <= 1'b0;
                            o_bus_error <= 1'b1;
                            state       <= IDLE;
                        end
                    end else begin
                        if (i_fetch) begin
                            pend_pc <= i_pc;
                            state   <= PF_WAIT;
                        end
                        if (i_flush) begin
                            pf_discard <= 1'b1;
                        end
                        if (done_c) begin
                            o_mem_rd <= 1'b0;
                            if (!i_fetch) begin
                                state <= IDLE;
                            end
                            if (i_mem_ack && !i_fetch && !i_flush && !pf_discard) begin
                                buf_valid <= 1'b1;
                                buf_addr  <= o_mem_addr;
                                buf_data  <= i_mem_data;
                            end
                        end
                    end
                end

                // Let the abandoned prefetch finish, leave one idle cycle, then read the jump target.
                PF_WAIT: begin
                    if (!o_mem_rd) begin
                        o_mem_rd   <= 1'b1;
                        o_mem_addr <= pend_pc;
                        tcount     <= '0;
                        state      <= READ;
                    end else if (done_c) begin
                        o_mem_rd <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dcpu_fetch.sv
// Bench for dcpu_fetch: directed scenarios plus randomized core/memory traffic, all
// compared cycle by cycle against a transaction-level reference model.
module tb_dcpu_fetch;

    localparam int unsigned AW  = 16;
    localparam int unsigned DW  = 16;
    localparam int          TMO = 15;
    localparam int          K_DEM  = 1;
    localparam int          K_PF   = 2;
    localparam int          K_DROP = 3;

    logic          clk;
    logic          rst_n;
    logic          fetch;
    logic [AW-1:0] pc;
    logic          flush;
    logic [DW-1:0] instr;
    logic          valid;
    logic          berr;
    logic [AW-1:0] mem_addr;
    logic          mem_rd;
    logic [DW-1:0] mem_data;
    logic          mem_ack;

    int n_checks;
    int n_errors;

    // Reference model: one bus transaction (kind + wait count), queues of pending reads.
    bit            m_busy;
    int            m_kind;
    int            m_wait;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_instr;
    bit            m_valid;
    bit            m_err;
    bit            m_buf_ok;
    logic [AW-1:0] m_buf_a;
    logic [DW-1:0] m_buf_d;
    logic [AW-1:0] pf_q[$];
    logic [AW-1:0] jump_q[$];

    dcpu_fetch #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .TIMEOUT   (TMO)
    ) dut (
        .i_clk              (clk),
        .i_reset_n          (rst_n),
        .i_fetch            (fetch),
        .i_pc               (pc),
        .i_flush            (flush),
        .o_instruction      (instr),
        .o_instruction_valid(valid),
        .o_bus_error        (berr),
        .o_mem_addr         (mem_addr),
        .o_mem_rd           (mem_rd),
        .i_mem_data         (mem_data),
        .i_mem_ack          (mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function void model_reset();
        m_busy   = 1'b0;
        m_kind   = 0;
        m_wait   = 0;
        m_addr   = '0;
        m_instr  = '0;
        m_valid  = 1'b0;
        m_err    = 1'b0;
        m_buf_ok = 1'b0;
        m_buf_a  = '0;
        m_buf_d  = '0;
        pf_q.delete();
        jump_q.delete();
    endfunction

    function void model_issue(input int kind, input logic [AW-1:0] a);
        m_busy = 1'b1;
        m_kind = kind;
        m_addr = a;
        m_wait = 0;
    endfunction

    function void model_deliver(input logic [DW-1:0] d, input logic [AW-1:0] a);
        logic [AW-1:0] nxt;
        nxt     = a + AW'(1);
        m_valid = 1'b1;
        m_instr = d;
        pf_q.push_back(nxt);
    endfunction

    // Effect of one rising edge given the inputs the DUT sampled.
    function void model_step();
        bit tmo;
        m_valid = 1'b0;
        m_err   = 1'b0;
        if (m_busy) begin
            tmo = !mem_ack && (m_wait == TMO - 1);
            if (m_kind == K_PF && fetch && !flush && pc == m_addr) begin
                m_kind = K_DEM;
            end else if (m_kind == K_PF && (fetch || flush)) begin
                m_kind = K_DROP;
                if (fetch) jump_q.push_back(pc);
            end else if (m_kind == K_DROP && fetch && jump_q.size() == 0) begin
                jump_q.push_back(pc);
            end
            if (mem_ack || tmo) begin
                m_busy = 1'b0;
                if (m_kind == K_DEM) begin
                    if (mem_ack) model_deliver(mem_data, m_addr);
                    else         m_err = 1'b1;
                end else if (m_kind == K_PF && mem_ack) begin
                    m_buf_ok = 1'b1;
                    m_buf_a  = m_addr;
                    m_buf_d  = mem_data;
                end
            end else begin
                m_wait++;
            end
        end else if (jump_q.size() != 0) begin
            model_issue(K_DEM, jump_q.pop_front());
        end else begin
            if (flush) begin
                m_buf_ok = 1'b0;
                pf_q.delete();
            end
            if (fetch) begin
                pf_q.delete();
                if (m_buf_ok && m_buf_a == pc) begin
                    m_buf_ok = 1'b0;
                    model_deliver(m_buf_d, pc);
                end else begin
                    m_buf_ok = 1'b0;
                    model_issue(K_DEM, pc);
                end
            end else if (pf_q.size() != 0) begin
                model_issue(K_PF, pf_q.pop_front());
            end
        end
    endfunction

    task automatic compare_all();
        check("rd",    32'(mem_rd),   32'(m_busy));
        check("addr",  32'(mem_addr), 32'(m_addr));
        check("valid", 32'(valid),    32'(m_valid));
        check("berr",  32'(berr),     32'(m_err));
        check("instr", 32'(instr),    32'(m_instr));
    endtask

    task automatic drive(input logic f, input logic [AW-1:0] p, input logic fl,
                         input logic a, input logic [DW-1:0] d);
        fetch    = f;
        pc       = p;
        flush    = fl;
        mem_ack  = a;
        mem_data = d;
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    initial begin
        logic [AW-1:0] last_pc;
        int            r;
        bit            starve;

        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0, '0);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        compare_all();
        rst_n = 1'b1;

        // Miss with two wait states, then prefetch of PC+1 after one idle cycle.
        drive(1'b1, 16'h0010, 1'b0, 1'b0, 16'h0000); step();
        check("t1_rd",   32'(mem_rd),   32'd1);
        check("t1_addr", 32'(mem_addr), 32'h0010);
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000); step(); step();
        drive(1'b0, 16'h0000, 1'b0, 1'b1, 16'h1234); step();
        check("t1_valid", 32'(valid), 32'd1);
        check("t1_instr", 32'(instr), 32'h1234);
        check("t1_rd_low", 32'(mem_rd), 32'd0);
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000); step();
        check("t1_pf_addr", 32'(mem_addr), 32'h0011);
        check("t1_pf_rd",   32'(mem_rd),   32'd1);

        // Sequential hit from the buffer.
        drive(1'b0, 16'h0000, 1'b0, 1'b1, 16'hBEEF); step();
        drive(1'b1, 16'h0011, 1'b0, 1'b0, 16'h0000); step();
        check("t2_valid", 32'(valid),  32'd1);
        check("t2_instr", 32'(instr),  32'hBEEF);
        check("t2_no_rd", 32'(mem_rd), 32'd0);
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000); step();
        check("t2_pf_addr", 32'(mem_addr), 32'h0012);

        // Jump while the prefetch of 0x0012 is in flight.
        drive(1'b1, 16'h0400, 1'b0, 1'b0, 16'h0000); step();
        check("t3_hold_addr", 32'(mem_addr), 32'h0012);
        drive(1'b0, 16'h0000, 1'b0, 1'b1, 16'hDEAD); step();
        check("t3_discard", 32'(valid), 32'd0);
        check("t3_gap",     32'(mem_rd), 32'd0);
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000); step();
        check("t3_jump_addr", 32'(mem_addr), 32'h0400);
        drive(1'b0, 16'h0000, 1'b0, 1'b1, 16'h4444); step();
        check("t3_instr", 32'(instr), 32'h4444);

        // Demand read that never gets an ack.
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000); step();
        drive(1'b0, 16'h0000, 1'b0, 1'b1, 16'h5555); step();
        drive(1'b1, 16'h0020, 1'b0, 1'b0, 16'h0000); step();
        check("t4_addr", 32'(mem_addr), 32'h0020);
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
        repeat (TMO - 1) step();
        check("t4_rd_held", 32'(mem_rd), 32'd1);
        step();
        check("t4_rd_drop", 32'(mem_rd), 32'd0);
        check("t4_berr",    32'(berr),   32'd1);
        check("t4_novalid", 32'(valid),  32'd0);
        step();
        check("t4_berr_pulse", 32'(berr), 32'd0);
        drive(1'b1, 16'h0030, 1'b0, 1'b0, 16'h0000); step();
        drive(1'b0, 16'h0000, 1'b0, 1'b1, 16'h3030); step();
        check("t4_recover", 32'(instr), 32'h3030);

        // Address wrap, then flush together with a fetch of the in-flight prefetch address.
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000); step();
        drive(1'b0, 16'h0000, 1'b0, 1'b1, 16'h3131); step();
        drive(1'b1, 16'hFFFF, 1'b0, 1'b0, 16'h0000); step();
        drive(1'b0, 16'h0000, 1'b0, 1'b1, 16'h7777); step();
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000); step();
        check("t5_wrap_addr", 32'(mem_addr), 32'h0000);
        check("t5_wrap_rd",   32'(mem_rd),   32'd1);
        drive(1'b1, 16'h0000, 1'b1, 1'b0, 16'h0000); step();
        drive(1'b0, 16'h0000, 1'b0, 1'b1, 16'h9999); step();
        check("t5_flushed", 32'(valid), 32'd0);
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000); step();
        check("t5_fresh_rd", 32'(mem_rd), 32'd1);
        drive(1'b0, 16'h0000, 1'b0, 1'b1, 16'h0A0A); step();
        check("t5_instr", 32'(instr), 32'h0A0A);

        // Asynchronous reset while a read is outstanding; later acks are stray.
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000); step();
        check("t6_rd_before", 32'(mem_rd), 32'd1);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("t6_rst_rd",    32'(mem_rd),   32'd0);
        check("t6_rst_addr",  32'(mem_addr), 32'd0);
        check("t6_rst_instr", 32'(instr),    32'd0);
        check("t6_rst_valid", 32'(valid),    32'd0);
        mem_ack  = 1'b1;
        mem_data = 16'hBAD0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (3) step();
        check("t6_stray_ack", 32'(mem_rd), 32'd0);

        // Randomized traffic, with periodic ack starvation to provoke timeouts.
        last_pc = 16'h0100;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            starve   = ((cyc / 150) % 4) == 3;
            fetch    = ($urandom_range(0, 3) == 0);
            flush    = ($urandom_range(0, 15) == 0);
            mem_ack  = starve ? 1'b0 : ($urandom_range(0, 2) == 0);
            mem_data = DW'($urandom);
            r = int'($urandom_range(0, 9));
            if (r < 4)      pc = last_pc + AW'(1);
            else if (r < 6) pc = m_addr;
            else if (r < 9) pc = AW'($urandom);
            else            pc = 16'hFFFF;
            if (fetch) last_pc = pc;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
